// File: rtl/intt_pkg.sv
// Shared definitions for the inverse-NTT sequencer: FSM state encoding,
// PE c-operand source codes and the modulus/coefficient width of the datapath.
package intt_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD,
    LAT,
    WA,
    WB,
    SRD,
    SLAT,
    SWR,
    DONE
  } state_t;

  localparam logic [1:0] CSEL_TW   = 2'd0;
  localparam logic [1:0] CSEL_ONE  = 2'd1;
  localparam logic [1:0] CSEL_NINV = 2'd2;

  localparam int Q      = 257;
  localparam int COEF_W = 9;

endpackage

// File: rtl/intt_ctrl_if.sv
// Control bus between the INTT sequencer and the coefficient RAM / PE datapath.
interface intt_ctrl_if #(
  parameter int LOGN = 3
) ();

  logic            start;
  logic            busy;
  logic            done;
  logic            mem_re;
  logic [LOGN-1:0] mem_ra;
  logic [LOGN-1:0] mem_rb;
  logic            op_le;
  logic            mem_we;
  logic [LOGN-1:0] mem_wa;
  logic            pe_sub;
  logic            pe_bz;
  logic [1:0]      c_sel;
  logic [LOGN-2:0] tw_idx;

  modport master (
    input  start,
    output busy, done, mem_re, mem_ra, mem_rb, op_le,
    output mem_we, mem_wa, pe_sub, pe_bz, c_sel, tw_idx
  );

  modport slave (
    output start,
    input  busy, done, mem_re, mem_ra, mem_rb, op_le,
    input  mem_we, mem_wa, pe_sub, pe_bz, c_sel, tw_idx
  );

endinterface

// File: rtl/intt_addr_gen.sv
// Stage/group/offset and scaling-index counters for the INTT walk; derives the
// butterfly pair addresses and the inverse-twiddle index.
module intt_addr_gen
  import intt_pkg::*;
#(
  parameter int LOGN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            step,
  input  logic            scl,
  output logic [LOGN-1:0] addr_j,
  output logic [LOGN-1:0] addr_jl,
  output logic [LOGN-1:0] addr_i,
  output logic [LOGN-2:0] tw_idx,
  output logic            last_bfly,
  output logic            last_stage,
  output logic            last_scale
);

  localparam int CW = LOGN + 1;
  localparam logic [CW-1:0] N = {1'b1, {LOGN{1'b0}}};

  logic [CW-1:0] s_reg, g_reg, k_reg, i_reg;
  logic [CW-1:0] len, k_inc, g_inc, sh;

  assign len   = CW'(1) << s_reg;
  assign k_inc = k_reg + CW'(1);
  assign g_inc = g_reg + (len << 1);
  assign sh    = CW'(LOGN - 1) - s_reg;

  assign addr_j  = g_reg[LOGN-1:0] + k_reg[LOGN-1:0];
  assign addr_jl = addr_j + len[LOGN-1:0];
  assign addr_i  = i_reg[LOGN-1:0];
  // k < len keeps the shifted index inside the n/2-entry ROM
  assign tw_idx  = k_reg[LOGN-2:0] << sh;

  assign last_bfly  = (k_inc == len) && (g_inc == N);
  assign last_stage = (s_reg == CW'(LOGN - 1));
  assign last_scale = (i_reg == N - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg <= '0;
      g_reg <= '0;
      k_reg <= '0;
      i_reg <= '0;
    end else if (clr) begin
      s_reg <= '0;
      g_reg <= '0;
      k_reg <= '0;
      i_reg <= '0;
    end else if (step) begin
      if (scl) begin
        i_reg <= i_reg + CW'(1);
      end else if (k_inc == len) begin
        k_reg <= '0;
        if (g_inc == N) begin
          g_reg <= '0;
          s_reg <= s_reg + CW'(1);
        end else begin
          g_reg <= g_inc;
        end
      end else begin
        k_reg <= k_inc;
      end
    end
  end

endmodule

// File: rtl/intt_ctrl.sv
// Gentleman-Sande inverse-NTT sequencer: four cycles per butterfly, then an
// optional n^-1 scaling pass, driving only RAM/PE control.
module intt_ctrl
  import intt_pkg::*;
#(
  parameter int LOGN  = 3,
  parameter bit SCALE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  intt_ctrl_if.master  bus
);

  state_t state_reg, state_next;

  logic            clr, step, scl;
  logic [LOGN-1:0] addr_j, addr_jl, addr_i;
  logic [LOGN-2:0] tw_idx;
  logic            last_bfly, last_stage, last_scale;

  intt_addr_gen #(.LOGN(LOGN)) u_addr (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .step       (step),
    .scl        (scl),
    .addr_j     (addr_j),
    .addr_jl    (addr_jl),
    .addr_i     (addr_i),
    .tw_idx     (tw_idx),
    .last_bfly  (last_bfly),
    .last_stage (last_stage),
    .last_scale (last_scale)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Outputs decode from the state register only, so an async reset clears them at once
  always_comb begin
    state_next  = state_reg;
    clr         = 1'b0;
    step        = 1'b0;
    scl         = 1'b0;
    bus.busy    = (state_reg != IDLE);
    bus.done    = 1'b0;
    bus.mem_re  = 1'b0;
    bus.mem_ra  = '0;
    bus.mem_rb  = '0;
    bus.op_le   = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_wa  = '0;
    bus.pe_sub  = 1'b0;
    bus.pe_bz   = 1'b0;
    bus.c_sel   = CSEL_TW;
    bus.tw_idx  = '0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          clr        = 1'b1;
          state_next = RD;
        end
      end
      RD: begin
        bus.mem_re = 1'b1;
        bus.mem_ra = addr_j;
        bus.mem_rb = addr_jl;
        state_next = LAT;
      end
      LAT: begin
        bus.op_le  = 1'b1;
        bus.tw_idx = tw_idx;
        state_next = WA;
      end
      WA: begin
        bus.mem_we = 1'b1;
        bus.mem_wa = addr_j;
        bus.c_sel  = CSEL_ONE;
        bus.tw_idx = tw_idx;
        state_next = WB;
      end
      WB: begin
        bus.mem_we = 1'b1;
        bus.mem_wa = addr_jl;
        bus.pe_sub = 1'b1;
        bus.c_sel  = CSEL_TW;
        bus.tw_idx = tw_idx;
        step       = 1'b1;
        if (last_bfly && last_stage) state_next = SCALE ? SRD : DONE;
        else                         state_next = RD;
      end
      SRD: begin
        bus.mem_re = 1'b1;
        bus.mem_ra = addr_i;
        bus.mem_rb = addr_i;
        state_next = SLAT;
      end
      SLAT: begin
        bus.op_le  = 1'b1;
        state_next = SWR;
      end
      SWR: begin
        bus.mem_we = 1'b1;
        bus.mem_wa = addr_i;
        bus.pe_bz  = 1'b1;
        bus.c_sel  = CSEL_NINV;
        step       = 1'b1;
        scl        = 1'b1;
        state_next = last_scale ? DONE : SRD;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_intt_ctrl.sv
// Cycle-exact check of the INTT sequencer (SCALE=1 and SCALE=0) plus a RAM/PE
// model that runs the emitted control and compares the transformed coefficients.
module tb_intt_ctrl;
  import intt_pkg::*;

  localparam int L    = 3;
  localparam int N    = 1 << L;
  localparam int NINV = 225;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  intt_ctrl_if #(.LOGN(L)) b1 ();
  intt_ctrl_if #(.LOGN(L)) b0 ();

  intt_ctrl #(.LOGN(L), .SCALE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  intt_ctrl #(.LOGN(L), .SCALE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  typedef struct packed {
    logic         busy, done, re;
    logic [L-1:0] ra, rb;
    logic         le, we;
    logic [L-1:0] wa;
    logic         sub, bz;
    logic [1:0]   csel;
    logic [L-2:0] tw;
  } vec_t;

  vec_t o1, o0;
  assign o1 = {b1.busy, b1.done, b1.mem_re, b1.mem_ra, b1.mem_rb, b1.op_le,
               b1.mem_we, b1.mem_wa, b1.pe_sub, b1.pe_bz, b1.c_sel, b1.tw_idx};
  assign o0 = {b0.busy, b0.done, b0.mem_re, b0.mem_ra, b0.mem_rb, b0.op_le,
               b0.mem_we, b0.mem_wa, b0.pe_sub, b0.pe_bz, b0.c_sel, b0.tw_idx};

  vec_t eq[$], e1[$], e0[$];
  int   errors = 0;
  int   checks = 0;

  // coefficient RAM, operand registers and inverse-twiddle ROM
  int ram[N], ld[N], ex[N], twr[N/2];
  int rda, rdb, opa, opb;
  bit ld_go = 1'b0;

  function automatic int pw(input int b, input int e);
    int r = 1;
    for (int x = 0; x < e; x++) r = (r * b) % Q;
    return r;
  endfunction

  function automatic int pe_f(input int a, input int b, input logic sub,
                              input logic bz, input logic [1:0] cs, input int w);
    int bb  = bz ? 0 : b;
    int sum = sub ? (a - bb + Q) % Q : (a + bb) % Q;
    int c   = (cs == CSEL_TW) ? w : (cs == CSEL_ONE) ? 1 : NINV;
    return (sum * c) % Q;
  endfunction

  always @(posedge clk) begin
    if (ld_go) begin
      for (int x = 0; x < N; x++) ram[x] <= ld[x];
    end else if (b1.mem_we) begin
      ram[b1.mem_wa] <= pe_f(opa, opb, b1.pe_sub, b1.pe_bz, b1.c_sel, twr[b1.tw_idx]);
    end
    if (b1.mem_re) begin
      rda <= ram[b1.mem_ra];
      rdb <= ram[b1.mem_rb];
    end
    if (b1.op_le) begin
      opa <= rda;
      opb <= rdb;
    end
  end

  // Expected per-cycle control trace, one entry per cycle after start is accepted
  task automatic gen_exp(input bit scale);
    vec_t v;
    eq = {};
    for (int s = 0; s < L; s++) begin
      int len = 1 << s;
      for (int g = 0; g < N; g += 2 * len) begin
        for (int k = 0; k < len; k++) begin
          int j = g + k;
          int jl = j + len;
          int t = k << (L - 1 - s);
          v = '0; v.busy = 1; v.re = 1; v.ra = j[L-1:0]; v.rb = jl[L-1:0]; eq.push_back(v);
          v = '0; v.busy = 1; v.le = 1; v.tw = t[L-2:0]; eq.push_back(v);
          v = '0; v.busy = 1; v.we = 1; v.wa = j[L-1:0]; v.csel = CSEL_ONE;
          v.tw = t[L-2:0]; eq.push_back(v);
          v = '0; v.busy = 1; v.we = 1; v.wa = jl[L-1:0]; v.sub = 1; v.csel = CSEL_TW;
          v.tw = t[L-2:0]; eq.push_back(v);
        end
      end
    end
    if (scale) begin
      for (int i = 0; i < N; i++) begin
        v = '0; v.busy = 1; v.re = 1; v.ra = i[L-1:0]; v.rb = i[L-1:0]; eq.push_back(v);
        v = '0; v.busy = 1; v.le = 1; eq.push_back(v);
        v = '0; v.busy = 1; v.we = 1; v.wa = i[L-1:0]; v.bz = 1; v.csel = CSEL_NINV;
        eq.push_back(v);
      end
    end
    v = '0; v.busy = 1; v.done = 1; eq.push_back(v);
  endtask

  // Arithmetic of the whole transform on the loaded vector
  task automatic ref_model();
    ex = ld;
    for (int s = 0; s < L; s++) begin
      int len = 1 << s;
      for (int g = 0; g < N; g += 2 * len) begin
        for (int k = 0; k < len; k++) begin
          int a = ex[g + k];
          int b = ex[g + k + len];
          ex[g + k]       = (a + b) % Q;
          ex[g + k + len] = (((a - b + Q) % Q) * twr[k << (L - 1 - s)]) % Q;
        end
      end
    end
    for (int i = 0; i < N; i++) ex[i] = (ex[i] * NINV) % Q;
  endtask

  task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s idx=%0d observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic cyc(input bit s1, input bit s0);
    @(negedge clk);
    b1.start = s1;
    b0.start = s0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input int ncyc, input bit load);
    vec_t x0;
    ld_go = load;
    cyc(1'b1, 1'b1);
    ld_go = 1'b0;
    chk("seq1", 1, 32'(o1), 32'(e1[0]));
    chk("seq0", 1, 32'(o0), 32'(e0[0]));
    for (int idx = 1; idx < ncyc; idx++) begin
      cyc(1'($urandom_range(0, 1)), 1'b0);
      x0 = (idx < e0.size()) ? e0[idx] : '0;
      chk("seq1", idx + 1, 32'(o1), 32'(e1[idx]));
      chk("seq0", idx + 1, 32'(o0), 32'(x0));
    end
    $display("xfer: %0d cycles checked, errors so far %0d", ncyc, errors);
  endtask

  task automatic chk_ram(input string tag, input bit use_ref);
    for (int i = 0; i < N; i++) begin
      int want = use_ref ? ex[i] : ((i == 0) ? 5 : 0);
      chk(tag, i, 32'(ram[i]), 32'(want));
    end
    $display("data %s: ram[0]=%0d ram[1]=%0d", tag, ram[0], ram[1]);
  endtask

  initial begin
    int w8 = 2;
    while (pw(w8, 4) != Q - 1) w8++;
    for (int t = 0; t < N / 2; t++) twr[t] = pw(pw(w8, N - 1), t);
    gen_exp(1'b1); e1 = eq;
    gen_exp(1'b0); e0 = eq;
    b1.start = 1'b0;
    b0.start = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset1", 0, 32'(o1), 32'd0);
    chk("reset0", 0, 32'(o0), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      chk("idle", i, 32'(o1), 32'd0);
    end

    // constant input, then start on the DONE cycle must be ignored
    for (int i = 0; i < N; i++) ld[i] = 5;
    run_xfer(e1.size(), 1'b1);
    cyc(1'b1, 1'b0);
    chk("done_start", 0, 32'(o1), 32'd0);
    chk_ram("const", 1'b0);

    // start in the idle cycle right after done, random coefficients
    for (int i = 0; i < N; i++) ld[i] = int'($urandom_range(0, Q - 1));
    ref_model();
    run_xfer(e1.size(), 1'b1);
    cyc(1'b0, 1'b0);
    chk("after_rand", 0, 32'(o1), 32'd0);
    chk_ram("rand", 1'b1);

    // asynchronous reset in the middle of stage 1
    for (int i = 0; i < N; i++) ld[i] = 5;
    run_xfer(20, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst1", 0, 32'(o1), 32'd0);
    chk("async_rst0", 0, 32'(o0), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0);
      chk("post_rst", i, 32'(o1), 32'd0);
    end
    run_xfer(e1.size(), 1'b1);
    cyc(1'b0, 1'b0);
    chk("final_idle", 0, 32'(o1), 32'd0);
    chk_ram("rerun", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
